// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe_if
// Brief    : Valid/ready bus bundle for the immediate-extension pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_extend_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immext;
    logic [TAG_W-1:0] out_tag;
    logic             illegal;

    modport slave (
        input  in_valid, instr, immsrc, in_tag, flush, out_ready,
        output in_ready, out_valid, immext, out_tag, illegal
    );

    modport master (
        output in_valid, instr, immsrc, in_tag, flush, out_ready,
        input  in_ready, out_valid, immext, out_tag, illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : RISC-V immediate decode/extend with a two-entry skid output stage.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    imm_extend_pipe_if.slave bus
);
    localparam logic c_SHAMT_HI_EN = (XLEN == 64);

    logic [63:0]      w_dec_imm64;
    logic             w_dec_illegal;
    logic             w_sign;
    logic             w_accept;
    logic             w_drain;
    logic             w_unused_ok;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q,   out_imm_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             out_ill_q,   out_ill_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             skid_ill_q,   skid_ill_d;
    logic             in_ready_q,   in_ready_d;

    assign w_sign      = bus.instr[31];
    assign w_unused_ok = ^{bus.instr[6:0], w_dec_imm64};

    // Everything is built at 64 bits and truncated, so one table serves both XLENs.
    always_comb begin
        w_dec_imm64   = '0;
        w_dec_illegal = 1'b0;
        case (bus.immsrc)
            3'b000:  w_dec_imm64 = {{52{w_sign}}, bus.instr[31:20]};
            3'b001:  w_dec_imm64 = {{52{w_sign}}, bus.instr[31:25], bus.instr[11:7]};
            3'b010:  w_dec_imm64 = {{51{w_sign}}, w_sign, bus.instr[7], bus.instr[30:25],
                                    bus.instr[11:8], 1'b0};
            3'b011:  w_dec_imm64 = {{43{w_sign}}, w_sign, bus.instr[19:12], bus.instr[20],
                                    bus.instr[30:21], 1'b0};
            3'b100:  w_dec_imm64 = {{32{w_sign}}, bus.instr[31:12], 12'b0};
            3'b101:  w_dec_imm64 = {59'b0, bus.instr[19:15]};
            3'b110:  w_dec_imm64 = {58'b0, c_SHAMT_HI_EN & bus.instr[25], bus.instr[24:20]};
            default: w_dec_illegal = 1'b1;
        endcase
    end

    assign w_accept = bus.in_valid && in_ready_q;
    assign w_drain  = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_drain || !out_valid_q) begin
            // OUT is free this edge; the skid entry is older than any new input.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                out_valid_d  = 1'b1;
                out_imm_d    = w_dec_imm64[XLEN-1:0];
                out_tag_d    = bus.in_tag;
                out_ill_d    = w_dec_illegal;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = w_dec_imm64[XLEN-1:0];
            skid_tag_d   = bus.in_tag;
            skid_ill_d   = w_dec_illegal;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.immext    = out_imm_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.illegal   = out_ill_q;
endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Brief    : Directed self-checking bench for imm_extend_pipe (XLEN 32 and 64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));
    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [2:0] src, input logic [31:0] ins,
                           input logic [4:0] tag);
        bus32.in_valid = v;
        bus32.immsrc   = src;
        bus32.instr    = ins;
        bus32.in_tag   = tag;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] imm,
                              input logic [4:0] otag, input logic ill);
        check({tag, "_valid"}, {63'b0, bus32.out_valid}, {63'b0, v});
        check({tag, "_imm"},   {32'b0, bus32.immext},    {32'b0, imm});
        check({tag, "_tag"},   {59'b0, bus32.out_tag},   {59'b0, otag});
        check({tag, "_ill"},   {63'b0, bus32.illegal},   {63'b0, ill});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive32(1'b0, 3'b000, 32'h0, 5'd0);
        bus32.flush     = 1'b0;
        bus32.out_ready = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.immsrc    = 3'b000;
        bus64.instr     = 32'h0;
        bus64.in_tag    = 5'd0;
        bus64.flush     = 1'b0;
        bus64.out_ready = 1'b1;

        // Reset state
        #12;
        expect_out("rst", 1'b0, 32'h0, 5'd0, 1'b0);
        check("rst_in_ready", {63'b0, bus32.in_ready}, 64'd0);
        #10 reset_n = 1'b1;
        tick();
        check("post_rst_in_ready", {63'b0, bus32.in_ready}, 64'd1);
        expect_out("post_rst", 1'b0, 32'h0, 5'd0, 1'b0);

        // Format decode, one per cycle with out_ready high
        drive32(1'b1, 3'b000, 32'hFFF00093, 5'd3); tick();
        expect_out("i_fmt", 1'b1, 32'hFFFFFFFF, 5'd3, 1'b0);
        drive32(1'b1, 3'b010, 32'hFE000FE3, 5'd4); tick();
        expect_out("b_fmt_a", 1'b1, 32'hFFFFFFFE, 5'd4, 1'b0);
        check("thru_in_ready", {63'b0, bus32.in_ready}, 64'd1);
        drive32(1'b1, 3'b010, 32'hFE000EE3, 5'd5); tick();
        expect_out("b_fmt_b", 1'b1, 32'hFFFFFFFC, 5'd5, 1'b0);
        drive32(1'b1, 3'b011, 32'hFFDFF06F, 5'd6); tick();
        expect_out("j_fmt", 1'b1, 32'hFFFFFFFC, 5'd6, 1'b0);
        drive32(1'b1, 3'b001, 32'hFE112E23, 5'd7); tick();
        expect_out("s_fmt", 1'b1, 32'hFFFFFFFC, 5'd7, 1'b0);
        drive32(1'b1, 3'b100, 32'h800000B7, 5'd8); tick();
        expect_out("u_fmt32", 1'b1, 32'h80000000, 5'd8, 1'b0);
        drive32(1'b1, 3'b101, 32'h800A8000, 5'd9); tick();
        expect_out("csr_fmt", 1'b1, 32'h00000015, 5'd9, 1'b0);
        drive32(1'b1, 3'b110, 32'h03F0D093, 5'd10); tick();
        expect_out("shamt32", 1'b1, 32'h0000001F, 5'd10, 1'b0);
        drive32(1'b1, 3'b111, 32'hFFFFFFFF, 5'd11); tick();
        expect_out("reserved", 1'b1, 32'h0, 5'd11, 1'b1);
        drive32(1'b0, 3'b000, 32'h0, 5'd0); tick();
        check("drained", {63'b0, bus32.out_valid}, 64'd0);

        // XLEN=64 instance
        bus64.in_valid = 1'b1; bus64.immsrc = 3'b100; bus64.instr = 32'h800000B7; bus64.in_tag = 5'd1;
        tick();
        check("u_fmt64", bus64.immext, 64'hFFFFFFFF80000000);
        bus64.immsrc = 3'b110; bus64.instr = 32'h03F0D093; bus64.in_tag = 5'd2;
        tick();
        check("shamt64", bus64.immext, 64'h000000000000003F);
        check("shamt64_tag", {59'b0, bus64.out_tag}, 64'd2);
        bus64.in_valid = 1'b0;

        // Backpressure: two entries, then drain in order
        bus32.out_ready = 1'b0;
        drive32(1'b1, 3'b000, 32'h00100093, 5'd1); tick();
        expect_out("bp_first", 1'b1, 32'h1, 5'd1, 1'b0);
        check("bp_ready1", {63'b0, bus32.in_ready}, 64'd1);
        drive32(1'b1, 3'b000, 32'h00200093, 5'd2); tick();
        check("bp_ready2", {63'b0, bus32.in_ready}, 64'd0);
        expect_out("bp_hold", 1'b1, 32'h1, 5'd1, 1'b0);
        drive32(1'b1, 3'b000, 32'h00300093, 5'd3); tick();
        expect_out("bp_stable", 1'b1, 32'h1, 5'd1, 1'b0);
        drive32(1'b0, 3'b000, 32'h0, 5'd0);
        bus32.out_ready = 1'b1; tick();
        expect_out("bp_second", 1'b1, 32'h2, 5'd2, 1'b0);
        check("bp_ready3", {63'b0, bus32.in_ready}, 64'd1);
        tick();
        check("bp_empty", {63'b0, bus32.out_valid}, 64'd0);

        // Flush at occupancy 2 with a concurrent input
        bus32.out_ready = 1'b0;
        drive32(1'b1, 3'b000, 32'h00600093, 5'd6); tick();
        drive32(1'b1, 3'b000, 32'h00700093, 5'd7); tick();
        drive32(1'b1, 3'b000, 32'h00800093, 5'd8);
        bus32.flush = 1'b1; tick();
        bus32.flush = 1'b0;
        check("fl2_valid", {63'b0, bus32.out_valid}, 64'd0);
        check("fl2_ready", {63'b0, bus32.in_ready}, 64'd1);
        drive32(1'b0, 3'b000, 32'h0, 5'd0);
        bus32.out_ready = 1'b1; tick();
        check("fl2_nothing", {63'b0, bus32.out_valid}, 64'd0);

        // Flush at occupancy 1 wins over a same-cycle accept
        bus32.out_ready = 1'b0;
        drive32(1'b1, 3'b000, 32'h00900093, 5'd9); tick();
        drive32(1'b1, 3'b000, 32'h00A00093, 5'd10);
        bus32.flush = 1'b1; tick();
        bus32.flush = 1'b0;
        drive32(1'b0, 3'b000, 32'h0, 5'd0);
        check("fl1_valid", {63'b0, bus32.out_valid}, 64'd0);
        bus32.out_ready = 1'b1; tick();
        check("fl1_nothing", {63'b0, bus32.out_valid}, 64'd0);

        // Asynchronous reset mid-stream at occupancy 2
        bus32.out_ready = 1'b0;
        drive32(1'b1, 3'b000, 32'h00B00093, 5'd11); tick();
        drive32(1'b1, 3'b000, 32'h00C00093, 5'd12); tick();
        drive32(1'b0, 3'b000, 32'h0, 5'd0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", {63'b0, bus32.out_valid}, 64'd0);
        check("arst_ready", {63'b0, bus32.in_ready}, 64'd0);
        check("arst_tag", {59'b0, bus32.out_tag}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("arst_rel_ready", {63'b0, bus32.in_ready}, 64'd1);
        check("arst_rel_valid", {63'b0, bus32.out_valid}, 64'd0);
        bus32.out_ready = 1'b1;
        drive32(1'b1, 3'b001, 32'h00112023, 5'd13); tick();
        expect_out("arst_push", 1'b1, 32'h0, 5'd13, 1'b0);
        drive32(1'b0, 3'b000, 32'h0, 5'd0); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
